// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline stage 4: data loads/stores on memory port B
//
// Purpose: takes the execute-stage bundle, issues at most one load or store on
// port B with a request/response handshake, aligns and extends load data, and
// forwards the bundle to writeback. Upstream is held while an access is in flight.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   regs_in / regs_out    stage bundle from execute / registered bundle to writeback
//   mdr_out               registered aligned/extended load data (0 for non-loads)
//   misaligned_out        registered flag: regs_out instruction was a misaligned access
//   stall_in / stall_out  downstream back-pressure / upstream hold
//   mem_*_b               port B request (address, read, write, byte enables, wdata)
//                         and response (rdata, single-cycle resp pulse)

package mem_access_stage_pkg;
    localparam int XLEN = 32;

    typedef struct packed {
        logic read_b;
        logic write;
        logic reg_we;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
    } stage_regs;
endpackage

module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int width = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  stage_regs        regs_in,
    output stage_regs        regs_out,
    output logic [width-1:0] mdr_out,
    output logic             misaligned_out,
    input  logic             stall_in,
    output logic             stall_out,
    output logic [width-1:0] mem_address_b,
    output logic             mem_read_b,
    output logic             mem_write_b,
    output logic [3:0]       mem_byte_enable_b,
    output logic [width-1:0] mem_wdata_b,
    input  logic [width-1:0] mem_rdata_b,
    input  logic             mem_resp_b
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] COMPLETE = 2'd2;

    logic [1:0]       r_state;
    stage_regs        r_regs;
    stage_regs        r_regs_out;
    logic [width-1:0] r_mdr_out;
    logic             r_misaligned_out;
    logic [width-1:0] r_load_data;
    logic [width-1:0] r_addr;
    logic [3:0]       r_be;
    logic [width-1:0] r_wdata;
    logic             r_is_read;
    logic             r_is_write;
    logic [1:0]       r_off;

    logic [1:0]       w_off;
    logic             w_is_mem;
    logic             w_misaligned;
    logic             w_issue;
    logic [3:0]       w_be;
    logic [width-1:0] w_wdata;
    logic [width-1:0] w_shifted;
    logic [width-1:0] w_load;

    // Decode of the incoming instruction; funct3[1:0] selects the access size.
    always_comb begin
        w_off        = regs_in.alu[1:0];
        w_is_mem     = regs_in.valid && (regs_in.ctrl.read_b || regs_in.ctrl.write);
        w_be         = 4'b1111;
        w_wdata      = regs_in.rs2;
        w_misaligned = 1'b0;
        case (regs_in.funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{regs_in.rs2[7:0]}};
            end
            2'b01: begin
                w_be         = 4'b0011 << w_off;
                w_wdata      = {2{regs_in.rs2[15:0]}};
                w_misaligned = w_off[0];
            end
            default: begin
                w_misaligned = (w_off != 2'b00);
            end
        endcase
        w_issue = (r_state == IDLE) && w_is_mem && !w_misaligned;
    end

    // Load alignment: shift the addressed lane down to bit 0, then extend.
    // Word accesses are always aligned here, so the shift is a no-op for them.
    always_comb begin
        w_shifted = mem_rdata_b >> {r_off, 3'b000};
        case (r_regs.funct3)
            3'b000:  w_load = {{(width-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load = {{(width-8){1'b0}}, w_shifted[7:0]};
            3'b001:  w_load = {{(width-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load = {{(width-16){1'b0}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        case (r_state)
            IDLE:     stall_out = w_issue ? 1'b1 : stall_in;
            ACCESS:   stall_out = 1'b1;
            default:  stall_out = stall_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_regs           <= '0;
            r_regs_out       <= '0;
            r_mdr_out        <= '0;
            r_misaligned_out <= 1'b0;
            r_load_data      <= '0;
            r_addr           <= '0;
            r_be             <= '0;
            r_wdata          <= '0;
            r_is_read        <= 1'b0;
            r_is_write       <= 1'b0;
            r_off            <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        // Issue ignores stall_in: the result is held in COMPLETE instead.
                        r_regs     <= regs_in;
                        r_addr     <= {regs_in.alu[width-1:2], 2'b00};
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_is_write <= regs_in.ctrl.write;
                        r_is_read  <= regs_in.ctrl.read_b && !regs_in.ctrl.write;
                        r_off      <= w_off;
                        r_state    <= ACCESS;
                    end else if (!stall_in) begin
                        // Only a misaligned mem op reaches here with w_is_mem set.
                        r_regs_out       <= regs_in;
                        r_mdr_out        <= '0;
                        r_misaligned_out <= w_is_mem;
                    end
                end
                ACCESS: begin
                    if (mem_resp_b) begin
                        r_load_data <= r_is_read ? w_load : '0;
                        r_state     <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    if (!stall_in) begin
                        r_regs_out       <= r_regs;
                        r_mdr_out        <= r_load_data;
                        r_misaligned_out <= 1'b0;
                        r_state          <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign regs_out          = r_regs_out;
    assign mdr_out           = r_mdr_out;
    assign misaligned_out    = r_misaligned_out;
    assign mem_address_b     = r_addr;
    assign mem_wdata_b       = r_wdata;
    assign mem_read_b        = (r_state == ACCESS) && r_is_read;
    assign mem_write_b       = (r_state == ACCESS) && r_is_write;
    assign mem_byte_enable_b = ((r_state == ACCESS) && r_is_write) ? r_be : 4'b0000;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    stage_regs   regs_in;
    stage_regs   regs_out;
    logic [31:0] mdr_out;
    logic        misaligned_out;
    logic        stall_in;
    logic        stall_out;
    logic [31:0] mem_address_b;
    logic        mem_read_b;
    logic        mem_write_b;
    logic [3:0]  mem_byte_enable_b;
    logic [31:0] mem_wdata_b;
    logic [31:0] mem_rdata_b;
    logic        mem_resp_b;

    int n_checks = 0;
    int n_err    = 0;

    stage_regs bubble;

    mem_access_stage #(.width(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .regs_in           (regs_in),
        .regs_out          (regs_out),
        .mdr_out           (mdr_out),
        .misaligned_out    (misaligned_out),
        .stall_in          (stall_in),
        .stall_out         (stall_out),
        .mem_address_b     (mem_address_b),
        .mem_read_b        (mem_read_b),
        .mem_write_b       (mem_write_b),
        .mem_byte_enable_b (mem_byte_enable_b),
        .mem_wdata_b       (mem_wdata_b),
        .mem_rdata_b       (mem_rdata_b),
        .mem_resp_b        (mem_resp_b)
    );

    always #5 clk = ~clk;

    function automatic stage_regs mk(input logic v, input logic rd_b, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] alu,
                                     input logic [31:0] rs2, input logic [31:0] pc);
        stage_regs r;
        r = '0;
        r.valid       = v;
        r.ctrl.read_b = rd_b;
        r.ctrl.write  = wr;
        r.ctrl.reg_we = rd_b;
        r.funct3      = f3;
        r.rd          = 5'd7;
        r.alu         = alu;
        r.rs2         = rs2;
        r.pc          = pc;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a mem op, respond after 'waits' idle ACCESS cycles, let it complete.
    task automatic run_op(input stage_regs r, input logic [31:0] rdata, input int waits);
        regs_in = r;
        tick();
        repeat (waits) tick();
        mem_resp_b  = 1'b1;
        mem_rdata_b = rdata;
        tick();
        mem_resp_b  = 1'b0;
        tick();
        regs_in = bubble;
    endtask

    initial begin
        bubble      = '0;
        reset       = 1'b1;
        regs_in     = bubble;
        stall_in    = 1'b0;
        mem_resp_b  = 1'b0;
        mem_rdata_b = '0;
        tick();
        tick();
        chk("rst_valid",  {31'd0, regs_out.valid}, 32'd0);
        chk("rst_mdr",    mdr_out, 32'd0);
        chk("rst_mis",    {31'd0, misaligned_out}, 32'd0);
        chk("rst_read",   {31'd0, mem_read_b}, 32'd0);
        chk("rst_write",  {31'd0, mem_write_b}, 32'd0);
        chk("rst_be",     {28'd0, mem_byte_enable_b}, 32'd0);
        chk("rst_addr",   mem_address_b, 32'd0);
        chk("rst_wdata",  mem_wdata_b, 32'd0);
        chk("rst_stall",  {31'd0, stall_out}, 32'd0);
        reset = 1'b0;
        tick();

        // lw 0x100, two wait cycles
        regs_in = mk(1, 1, 0, 3'b010, 32'h100, 32'h0, 32'h1000);
        #1;
        chk("lw_issue_stall", {31'd0, stall_out}, 32'd1);
        chk("lw_issue_noreq", {31'd0, mem_read_b}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                mem_resp_b  = 1'b1;
                mem_rdata_b = 32'hDEADBEEF;
                #1;
            end
            chk("lw_read",  {31'd0, mem_read_b}, 32'd1);
            chk("lw_write", {31'd0, mem_write_b}, 32'd0);
            chk("lw_addr",  mem_address_b, 32'h100);
            chk("lw_stall", {31'd0, stall_out}, 32'd1);
            chk("lw_hold",  {31'd0, regs_out.valid}, 32'd0);
            tick();
        end
        mem_resp_b = 1'b0;
        #1;
        chk("lw_req_drop", {31'd0, mem_read_b}, 32'd0);
        tick();
        regs_in = bubble;
        chk("lw_mdr",   mdr_out, 32'hDEADBEEF);
        chk("lw_valid", {31'd0, regs_out.valid}, 32'd1);
        chk("lw_pc",    regs_out.pc, 32'h1000);
        chk("lw_mis",   {31'd0, misaligned_out}, 32'd0);

        // narrow loads, rdata = 0x80F07F81
        run_op(mk(1, 1, 0, 3'b000, 32'h200, 0, 32'h1100), 32'h80F07F81, 0);
        chk("lb_off0", mdr_out, 32'hFFFFFF81);
        run_op(mk(1, 1, 0, 3'b100, 32'h203, 0, 32'h1104), 32'h80F07F81, 1);
        chk("lbu_off3", mdr_out, 32'h00000080);
        run_op(mk(1, 1, 0, 3'b001, 32'h202, 0, 32'h1108), 32'h80F07F81, 0);
        chk("lh_off2", mdr_out, 32'hFFFF80F0);
        run_op(mk(1, 1, 0, 3'b101, 32'h200, 0, 32'h110C), 32'h80F07F81, 0);
        chk("lhu_off0", mdr_out, 32'h00007F81);
        chk("lhu_pc",   regs_out.pc, 32'h110C);

        // sb rs2=0x12345678 off=2
        regs_in = mk(1, 0, 1, 3'b000, 32'h302, 32'h12345678, 32'h1200);
        tick();
        chk("sb_write", {31'd0, mem_write_b}, 32'd1);
        chk("sb_read",  {31'd0, mem_read_b}, 32'd0);
        chk("sb_be",    {28'd0, mem_byte_enable_b}, 32'h4);
        chk("sb_wdata", mem_wdata_b, 32'h78787878);
        chk("sb_addr",  mem_address_b, 32'h300);
        chk("sb_hold",  regs_out.pc, 32'h110C);
        mem_resp_b  = 1'b1;
        mem_rdata_b = 32'hCAFEF00D;
        tick();
        mem_resp_b = 1'b0;
        chk("sb_be_off", {28'd0, mem_byte_enable_b}, 32'h0);
        tick();
        regs_in = bubble;
        chk("sb_mdr", mdr_out, 32'h0);
        chk("sb_pc",  regs_out.pc, 32'h1200);

        // sh off=2
        regs_in = mk(1, 0, 1, 3'b001, 32'h302, 32'h12345678, 32'h1204);
        tick();
        chk("sh_be",    {28'd0, mem_byte_enable_b}, 32'hC);
        chk("sh_wdata", mem_wdata_b, 32'h56785678);
        chk("sh_hold",  regs_out.pc, 32'h1200);
        mem_resp_b = 1'b1;
        tick();
        mem_resp_b = 1'b0;
        tick();
        regs_in = bubble;
        chk("sh_pc", regs_out.pc, 32'h1204);

        // misaligned lw: no request, flag one cycle later
        regs_in = mk(1, 1, 0, 3'b010, 32'h102, 0, 32'h1300);
        #1;
        chk("mis_stall", {31'd0, stall_out}, 32'd0);
        chk("mis_noreq", {31'd0, mem_read_b}, 32'd0);
        tick();
        regs_in = bubble;
        chk("mis_flag",  {31'd0, misaligned_out}, 32'd1);
        chk("mis_mdr",   mdr_out, 32'h0);
        chk("mis_pc",    regs_out.pc, 32'h1300);
        chk("mis_noreq2", {31'd0, mem_read_b}, 32'd0);
        tick();
        chk("mis_clear", {31'd0, misaligned_out}, 32'd0);

        // valid=0 with read set never touches memory
        regs_in = mk(0, 1, 0, 3'b010, 32'h100, 0, 32'h0);
        #1;
        chk("inv_stall", {31'd0, stall_out}, 32'd0);
        tick();
        chk("inv_noreq", {31'd0, mem_read_b}, 32'd0);
        regs_in = bubble;

        // response while downstream stalled for 4 cycles
        regs_in = mk(1, 1, 0, 3'b010, 32'h500, 0, 32'h6000);
        tick();
        mem_resp_b  = 1'b1;
        mem_rdata_b = 32'h11223344;
        stall_in    = 1'b1;
        tick();
        mem_resp_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stl_stall", {31'd0, stall_out}, 32'd1);
            chk("stl_hold",  {31'd0, regs_out.valid}, 32'd0);
            chk("stl_noreq", {31'd0, mem_read_b}, 32'd0);
            tick();
        end
        stall_in = 1'b0;
        #1;
        chk("stl_release", {31'd0, stall_out}, 32'd0);
        tick();
        regs_in = bubble;
        chk("stl_pc",  regs_out.pc, 32'h6000);
        chk("stl_mdr", mdr_out, 32'h11223344);

        // spurious response in IDLE while held
        stall_in    = 1'b1;
        mem_resp_b  = 1'b1;
        mem_rdata_b = 32'hFFFFFFFF;
        tick();
        mem_resp_b = 1'b0;
        chk("spur_mdr",   mdr_out, 32'h11223344);
        chk("spur_noreq", {31'd0, mem_read_b}, 32'd0);
        chk("spur_pc",    regs_out.pc, 32'h6000);
        stall_in = 1'b0;
        tick();
        chk("spur_after", mdr_out, 32'h0);

        // reset during ACCESS abandons the access
        regs_in = mk(1, 1, 0, 3'b010, 32'h400, 0, 32'h5000);
        tick();
        chk("rsta_read", {31'd0, mem_read_b}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        regs_in = bubble;
        #1;
        chk("rsta_read0",  {31'd0, mem_read_b}, 32'd0);
        chk("rsta_addr",   mem_address_b, 32'h0);
        chk("rsta_valid",  {31'd0, regs_out.valid}, 32'd0);
        chk("rsta_mdr",    mdr_out, 32'h0);
        chk("rsta_stall",  {31'd0, stall_out}, 32'd0);
        mem_resp_b  = 1'b1;
        mem_rdata_b = 32'h00000123;
        tick();
        mem_resp_b = 1'b0;
        tick();
        tick();
        chk("rsta_late_mdr",   mdr_out, 32'h0);
        chk("rsta_late_valid", {31'd0, regs_out.valid}, 32'd0);
        chk("rsta_late_read",  {31'd0, mem_read_b}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage 4. It consumes the execute-stage register bundle, performs data loads and stores on memory port B with a request/response handshake, and presents aligned load data plus the forwarded bundle to writeback.
- It owns port B's request signals.
- It stalls the upstream pipeline while an access is outstanding.

Parameters:
- width, 32, datapath width; address, store data and load data are all `width` bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- regs_in  in  $bits(stage_regs)  bundle from execute. Fields used:
  - valid
  - ctrl.read_b
  - ctrl.write
  - funct3
  - alu (byte address)
  - rs2 (store data)
- regs_out  out  $bits(stage_regs)  registered bundle to writeback
- mdr_out  out  width  registered aligned/extended load data
- misaligned_out  out  1  registered; the instruction in regs_out was a misaligned access
- stall_in  in  1  high means downstream cannot accept a new result this cycle
- stall_out  out  1  high means upstream must hold; this stage accepts no new instruction this cycle
- mem_address_b  out  width  word-aligned address, equal to alu with bits [1:0] forced to 0
- mem_read_b  out  1  read request
- mem_write_b  out  1  write request
- mem_byte_enable_b  out  4  byte lanes written
- mem_wdata_b  out  width  lane-replicated store data
- mem_rdata_b  in  width  read data, valid when mem_resp_b=1
- mem_resp_b  in  1  single-cycle completion pulse

Behaviour:
- A memory op is defined as regs_in.valid && (ctrl.read_b || ctrl.write). An instruction with valid=0 never accesses memory.
- funct3 encoding:
  - 000 = byte (lb/sb)
  - 001 = half (lh/sh)
  - 010 = word
  - 100 = lbu
  - 101 = lhu
- off = alu[1:0]. An access is misaligned when:
  - half with off=3, or off=1 for sh/lh as well; half requires off[0]=0, or
  - word with off≠0.
- Store encoding:
  - byte: be = 4'b0001<<off, wdata = {4{rs2[7:0]}}
  - half: be = 4'b0011<<off, wdata = {2{rs2[15:0]}}
  - word: be = 4'b1111, wdata = rs2
- Load alignment:
  - byte: mem_rdata_b[8*off+7 : 8*off], sign-extended, or zero-extended for funct3=100
  - half: mem_rdata_b[8*off+15 : 8*off], sign-extended, or zero-extended for funct3=101
  - word: mem_rdata_b unchanged
- FSM states: IDLE, ACCESS, COMPLETE.
- IDLE:
  - Non-mem op or valid=0: stall_out = stall_in. If !stall_in, at the edge regs_out<=regs_in, mdr_out<=0, misaligned_out<=0; otherwise hold all outputs. Latency is 1 cycle.
  - Misaligned mem op: no memory request. It behaves as a non-mem op, except misaligned_out<=1 and mdr_out<=0.
  - Aligned mem op: stall_out=1. Latch the bundle, address, be, wdata and the read/write command, then go to ACCESS. stall_in is ignored at issue.
- ACCESS:
  - mem_read_b or mem_write_b stays high, never both.
  - Address, be and wdata stay stable from latched values until mem_resp_b.
  - stall_out=1.
  - On mem_resp_b: capture the aligned load data (0 for stores), drop the request in the next cycle, and go to COMPLETE.
  - With zero wait states the sequence is IDLE→ACCESS→COMPLETE, so minimum latency is 3 cycles.
- COMPLETE:
  - stall_out = stall_in.
  - If !stall_in: regs_out<=latched bundle, mdr_out<=captured data, misaligned_out<=0, go to IDLE.
  - Otherwise hold in COMPLETE.
- mem_read_b and mem_write_b are 0 outside ACCESS, and mem_byte_enable_b is 0 except during a write in ACCESS.
- mem_resp_b arriving outside ACCESS is ignored.
- Reset values:
  - state=IDLE
  - regs_out=0 (valid=0)
  - mdr_out=0, misaligned_out=0
  - mem_read_b=0, mem_write_b=0, mem_byte_enable_b=0
  - mem_address_b=0, mem_wdata_b=0
  - stall_out=0
- Reset in ACCESS abandons the access: requests are 0 in the cycle after reset, and a late mem_resp_b is ignored.
- Reset has priority over mem_resp_b in the same cycle.

Test Plan:
- lw, alu=0x100, resp after 2 wait cycles, rdata=0xDEADBEEF:
  - mem_read_b high for 3 cycles at addr 0x100
  - stall_out high throughout
  - then mdr_out=0xDEADBEEF and regs_out.valid=1
- lb / lbu / lh / lhu with rdata=0x80F0_7F81:
  - lb off=0 → 0xFFFFFF81
  - lbu off=3 → 0x00000080
  - lh off=2 → 0xFFFF80F0
  - lhu off=0 → 0x00007F81
- sb rs2=0x12345678 off=2: be=4'b0100, wdata=0x78787878. sh off=2: be=4'b1100, wdata=0x56785678. No regs_out update before resp.
- lw alu=0x102: no mem_read_b; misaligned_out=1 and mdr_out=0 one cycle later.
- Resp arrives while stall_in=1 for 4 cycles: stage holds in COMPLETE, regs_out unchanged, stall_out=1; it advances in the cycle stall_in falls. A spurious mem_resp_b in IDLE has no effect.
- Reset asserted in ACCESS mid-wait: all outputs are at reset values the next cycle, and a subsequent mem_resp_b pulse produces no output.
